// File: rtl/sqrt_range_pipe.sv
// Three-stage range reduction ahead of a square root: normalises the mantissa so the exponent is even, then halves the exponent.
// Optional zero_out result flag, enabled by defining SQRT_RANGE_ZERO_FLAG_EN.
module sqrt_range_pipe #(
   parameter int DATA_W = 21,
   parameter int EXP_W  = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        f_in,
   input  logic signed [EXP_W-1:0]  exp_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        f_out,
   output logic signed [EXP_W-1:0]  exp_out,
`ifdef SQRT_RANGE_ZERO_FLAG_EN
   output logic                     zero_out,
`endif
   output logic                     busy
);

   localparam int LZ_W = $clog2(DATA_W);
   localparam int SH_W = LZ_W + 1;

   // A wider mantissa than the exponent can absorb could overflow exp_out.
   if (DATA_W - 1 > 2 ** (EXP_W - 1)) begin : g_param_check
      $error("sqrt_range_pipe: DATA_W-1 exceeds 2^(EXP_W-1), exp_out may overflow");
   end

   logic                     s1_valid;
   logic [DATA_W-1:0]        s1_f;
   logic signed [EXP_W-1:0]  s1_exp;
   logic                     s2_valid;
   logic [DATA_W-1:0]        s2_f;
   logic signed [EXP_W-1:0]  s2_exp;
   logic signed [SH_W-1:0]   s2_sh;

   logic                     s3_ready;
   logic                     s2_ready;
   logic [LZ_W-1:0]          lz;
   logic                     found;
   logic signed [SH_W-1:0]   lz_s;
   logic signed [SH_W-1:0]   s1_sh;
   logic                     s2_zero;
   logic [DATA_W-1:0]        f_next;
   logic signed [EXP_W:0]    exp_diff;
   logic signed [EXP_W-1:0]  exp_next;

   assign s3_ready = !out_valid || out_ready;
   assign s2_ready = !s2_valid || s3_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign busy     = s1_valid || s2_valid || out_valid;

   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (!found && s1_f[i]) begin
            lz    = LZ_W'(DATA_W - 1 - i);
            found = 1'b1;
         end
      end
   end

   // (exp - lz) is odd exactly when their LSBs differ; back off one shift to make it even.
   assign lz_s  = signed'({1'b0, lz});
   assign s1_sh = (s1_exp[0] ^ lz[0]) ? lz_s - SH_W'(1) : lz_s;

   assign s2_zero  = (s2_f == '0);
   assign exp_diff = (EXP_W + 1)'(s2_exp) - (EXP_W + 1)'(s2_sh);

   always_comb begin
      f_next   = '0;
      exp_next = '0;
      if (!s2_zero) begin
         if (s2_sh[SH_W-1]) begin
            f_next = s2_f >> 1;
         end else begin
            f_next = s2_f << s2_sh[SH_W-2:0];
         end
         exp_next = EXP_W'(exp_diff >>> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_f     <= '0;
         s1_exp   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_f   <= f_in;
            s1_exp <= exp_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_f     <= '0;
         s2_exp   <= '0;
         s2_sh    <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_f   <= s1_f;
            s2_exp <= s1_exp;
            s2_sh  <= s1_sh;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         f_out     <= '0;
         exp_out   <= '0;
      end else if (s3_ready) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            f_out   <= f_next;
            exp_out <= exp_next;
         end
      end
   end

`ifdef SQRT_RANGE_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_out <= 1'b0;
      end else if (s3_ready && s2_valid) begin
         zero_out <= s2_zero;
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_range_pipe.sv
// Self-checking bench for sqrt_range_pipe: directed vectors, stall/reset sequences and a randomized scoreboard run.
// zero_out is checked only when SQRT_RANGE_ZERO_FLAG_EN is defined.
module tb_sqrt_range_pipe;

   localparam int DATA_W = 21;
   localparam int EXP_W  = 6;

   typedef struct {
      logic [DATA_W-1:0] f;
      int                e;
      bit                z;
      int                acc_cycle;
   } exp_t;

   typedef struct {
      logic [DATA_W-1:0]       f;
      logic signed [EXP_W-1:0] e;
      logic [DATA_W-1:0]       ef;
      int                      ee;
      bit                      ez;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [DATA_W-1:0]       f_in = '0;
   logic signed [EXP_W-1:0] exp_in = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [DATA_W-1:0]       f_out;
   logic signed [EXP_W-1:0] exp_out;
   logic                    busy;
`ifdef SQRT_RANGE_ZERO_FLAG_EN
   logic                    zero_out;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   inflight = 0;
   bit   check_lat = 1'b0;
   bit   hold_prev = 1'b0;
   logic [DATA_W-1:0]       f_prev = '0;
   logic signed [EXP_W-1:0] e_prev = '0;
   exp_t sb[$];
   vec_t vecs[10];

   sqrt_range_pipe #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f_in      (f_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f_out     (f_out),
      .exp_out   (exp_out),
`ifdef SQRT_RANGE_ZERO_FLAG_EN
      .zero_out  (zero_out),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: normalise, pick the shift that leaves an even exponent, then halve.
   function automatic exp_t refModel(input logic [DATA_W-1:0] f, input logic signed [EXP_W-1:0] e);
      exp_t r;
      int   ei;
      int   lz;
      int   sh;
      ei = e;
      r.acc_cycle = 0;
      if (f == 0) begin
         r.f = '0;
         r.e = 0;
         r.z = 1'b1;
         return r;
      end
      lz = 0;
      while (f[DATA_W-1-lz] == 1'b0) lz++;
      sh = (((ei - lz) % 2) == 0) ? lz : lz - 1;
      r.f = (sh >= 0) ? (f << sh) : (f >> 1);
      r.e = (ei - sh) / 2;
      r.z = 1'b0;
      return r;
   endfunction

   function automatic exp_t fromVec(input vec_t v);
      exp_t r;
      r.f = v.ef;
      r.e = v.ee;
      r.z = v.ez;
      r.acc_cycle = 0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One clock cycle: drive, sample at negedge, score, advance to posedge+1.
   task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] f, input logic signed [EXP_W-1:0] e,
                                input bit ordy, input exp_t expv, output bit acc);
      exp_t got;
      bit   emit;
      in_valid  = v;
      f_in      = f;
      exp_in    = e;
      out_ready = ordy;
      @(negedge clk);
      checkOutput("in_ready", in_ready, !(inflight == 3 && !ordy));
      checkOutput("busy", busy, inflight != 0);
      if (hold_prev) begin
         checkOutput("hold_valid", out_valid, 1);
         checkOutput("hold_f", f_out, f_prev);
         checkOutput("hold_exp", exp_out, e_prev);
      end
      acc  = v && in_ready;
      emit = out_valid && ordy;
      if (emit) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_out actual f_out=%0h exp_out=%0d required no output", f_out, exp_out);
         end else begin
            got = sb.pop_front();
            checkOutput("f_out", f_out, got.f);
            checkOutput("exp_out", exp_out, got.e);
`ifdef SQRT_RANGE_ZERO_FLAG_EN
            checkOutput("zero_out", zero_out, got.z);
`endif
            if (check_lat) checkOutput("latency", cycle - got.acc_cycle, 3);
         end
      end
      hold_prev = out_valid && !ordy;
      f_prev    = f_out;
      e_prev    = exp_out;
      if (acc) begin
         expv.acc_cycle = cycle;
         sb.push_back(expv);
      end
      inflight = inflight + int'(acc) - int'(emit && (inflight > 0));
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic drain(input string name, input int bound);
      bit   acc;
      exp_t dummy;
      dummy = refModel('0, '0);
      for (int i = 0; i < bound && sb.size() != 0; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1, dummy, acc);
      end
      checkOutput(name, sb.size(), 0);
   endtask

   initial begin
      bit   acc;
      int   idx;
      exp_t m;
      logic [DATA_W-1:0]       rf;
      logic signed [EXP_W-1:0] re;
      logic [DATA_W-1:0]       sf[5];
      logic signed [EXP_W-1:0] se[5];

      vecs[0] = '{21'h000001,  6'sd0,   21'h100000, -10, 1'b0};
      vecs[1] = '{21'h100000,  6'sd1,   21'h080000,   1, 1'b0};
      vecs[2] = '{21'h0C0000,  6'sd0,   21'h0C0000,   0, 1'b0};
      vecs[3] = '{21'h000000,  6'sd7,   21'h000000,   0, 1'b1};
      vecs[4] = '{21'h1FFFFF,  6'sd0,   21'h1FFFFF,   0, 1'b0};
      vecs[5] = '{21'h1FFFFF,  6'sd1,   21'h0FFFFF,   1, 1'b0};
      vecs[6] = '{21'h000003, -6'sd3,   21'h180000, -11, 1'b0};
      vecs[7] = '{21'h000001, -6'sd32,  21'h100000, -26, 1'b0};
      vecs[8] = '{21'h000001,  6'sd31,  21'h080000,   6, 1'b0};
      vecs[9] = '{21'h100001,  6'sd31,  21'h080000,  16, 1'b0};

      #3 rst_n = 1'b0;
      #4;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_f_out", f_out, 0);
      checkOutput("reset_exp_out", exp_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed vectors");
      check_lat = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, vecs[i].f, vecs[i].e, 1'b1, fromVec(vecs[i]), acc);
         checkOutput("vec_accept", acc, 1);
         drain("vec_drain", 8);
      end

      $display("[TB] back-to-back stream");
      for (int i = 0; i < 10; i++) begin
         rf = DATA_W'($urandom) >> $urandom_range(0, DATA_W - 1);
         re = EXP_W'($urandom);
         applyStimulus(1'b1, rf, re, 1'b1, refModel(rf, re), acc);
         checkOutput("b2b_accept", acc, 1);
      end
      drain("b2b_drain", 8);

      $display("[TB] stall with five samples");
      check_lat = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sf[i] = DATA_W'($urandom) >> $urandom_range(0, DATA_W - 1);
         se[i] = EXP_W'($urandom);
      end
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, sf[idx], se[idx], 1'b0, refModel(sf[idx], se[idx]), acc);
         if (acc) idx++;
      end
      checkOutput("stall_accepts", idx, 3);
      checkOutput("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 20 && (idx < 5 || sb.size() != 0); i++) begin
         if (idx < 5) begin
            applyStimulus(1'b1, sf[idx], se[idx], 1'b1, refModel(sf[idx], se[idx]), acc);
            if (acc) idx++;
         end else begin
            applyStimulus(1'b0, '0, '0, 1'b1, refModel('0, '0), acc);
         end
      end
      checkOutput("stall_all_accepted", idx, 5);
      checkOutput("stall_drain", sb.size(), 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         rf = DATA_W'($urandom) >> $urandom_range(0, DATA_W);
         re = EXP_W'($urandom);
         applyStimulus($urandom_range(0, 3) != 0, rf, re, $urandom_range(0, 3) != 0, refModel(rf, re), acc);
      end
      drain("random_drain", 20);

      $display("[TB] reset with samples in flight");
      for (int i = 0; i < 3; i++) begin
         rf = DATA_W'($urandom) | 21'h1;
         applyStimulus(1'b1, rf, '0, 1'b0, refModel(rf, '0), acc);
      end
      checkOutput("pre_reset_busy", busy, 1);
      checkOutput("pre_reset_out_valid", out_valid, 1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", out_valid, 0);
      checkOutput("mid_reset_busy", busy, 0);
      checkOutput("mid_reset_f_out", f_out, 0);
      sb.delete();
      inflight  = 0;
      hold_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1, refModel('0, '0), acc);
      end
      check_lat = 1'b1;
      applyStimulus(1'b1, vecs[0].f, vecs[0].e, 1'b1, fromVec(vecs[0]), acc);
      checkOutput("post_reset_accept", acc, 1);
      drain("post_reset_drain", 8);

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/sqrt_range_pipe.md
SQRT_RANGE_PIPE -- requirements
Module: sqrt_range_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 21, mantissa width of f_in/f_out.
REQ-002 SHALL have parameter EXP_W, default 6, two's-complement exponent width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input sample valid.
REQ-006 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-007 SHALL have port f_in  input  DATA_W  unsigned mantissa.
REQ-008 SHALL have port exp_in  input  EXP_W  signed exponent.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port f_out  output  DATA_W  range-reduced mantissa.
REQ-012 SHALL have port exp_out  output  EXP_W  signed halved exponent.
REQ-013 SHALL have port busy  output  1  any pipeline stage holds a valid sample.
REQ-014 SHALL have port zero_out  output  1  result came from f_in==0 (present only under SQRT_RANGE_ZERO_FLAG_EN).

Function
REQ-015 SHALL compute lz = leading-zero count of f_in, range 0..DATA_W-1 for nonzero f_in.
REQ-016 SHALL select shift sh = lz when (exp_in - lz) is even, else sh = lz-1 (sh=-1 means right shift by 1).
REQ-017 SHALL output f_out = f_in << sh for sh>=0, f_in >> 1 (LSB truncated) for sh=-1; leading one lands in bit DATA_W-1 or DATA_W-2.
REQ-018 SHALL output exp_out = (exp_in - sh)/2, computed at EXP_W+1 bits, exact (operand always even).
REQ-019 SHALL, for f_in==0, output f_out=0, exp_out=0.
REQ-020 SHALL be a 3-stage pipeline: S1 registers inputs, S2 computes lz/sh, S3 shifts and forms exponent.
REQ-021 SHALL transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-022 SHALL present a sample accepted at edge N on f_out/exp_out with out_valid=1 after edge N+2 (latency 3 cycles incl. acceptance), given no stall.
REQ-023 SHALL sustain 1 sample/cycle when out_ready held high.
REQ-024 SHALL advance each stage when its successor is empty or advancing in the same cycle; in_ready = S1 empty or S1 advancing.
REQ-025 SHALL hold f_out/exp_out/out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL preserve order; no sample dropped or duplicated under any out_ready pattern.
REQ-027 SHALL hold at most 3 samples; in_ready=0 when all 3 stages full and out_ready=0.
REQ-028 SHALL accept a new input in the same cycle a full pipeline drains one output.
REQ-029 SHALL drive busy = OR of the three stage valid bits.

Reset
REQ-030 SHALL, on rst_n low, immediately clear all stage valid bits; out_valid=0, busy=0, f_out=0, exp_out=0, zero_out=0.
REQ-031 SHALL discard in-flight samples on reset mid-operation; in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with SQRT_RANGE_ZERO_FLAG_EN defined, provide zero_out, pipelined with the sample, 1 iff f_in==0.
REQ-033 SHALL, without SQRT_RANGE_ZERO_FLAG_EN, omit zero_out and its pipeline register; all other behaviour identical.
REQ-034 SHALL reject at elaboration DATA_W-1 > 2^(EXP_W-1) (exp_out overflow possible).

Verification (DATA_W=21, EXP_W=6)
REQ-035 f_in=0x00001, exp_in=0 -> f_out=0x100000, exp_out=-10.
REQ-036 f_in=0x100000, exp_in=1 -> f_out=0x080000, exp_out=1; f_in=0x0C0000, exp_in=0 -> f_out=0x0C0000, exp_out=0.
REQ-037 f_in=0, exp_in=7 -> f_out=0, exp_out=0, zero_out=1 (macro defined).
REQ-038 10 back-to-back samples, out_ready=1 -> 10 results on consecutive cycles, first 3 cycles after first accept, in order.
REQ-039 5 samples with out_ready=0 for 6 cycles -> in_ready=0 after 3 accepted, output stable; out_ready=1 -> all 5 emerge in order.
REQ-040 rst_n pulsed low with 3 samples in flight -> out_valid=0, busy=0 at once; none of those samples ever emerges.
